fg_prog_sequencer: RTL
======================

FG_PROG_SEQUENCER -- requirements
Module: fg_prog_sequencer

Interface
REQ-001 Parameter ROW_BITS, default 5, vertical VinjDecode2to4 address width.
REQ-002 Parameter COL_BITS, default 6, horizontal VinjDecode2to4 address width.
REQ-003 Parameter CNT_BITS, default 12, settle/pulse timer width.
REQ-004 Parameter MEAS_BITS, default 10, measurement and target width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  sequencer can accept a command.
REQ-009 cmd_row  in  ROW_BITS  target FG row.
REQ-010 cmd_col  in  COL_BITS  target FG column.
REQ-011 cmd_tun  in  1  1 = single tunnel (erase) pulse; 0 = inject-to-target loop.
REQ-012 cmd_target  in  MEAS_BITS  inject stop threshold.
REQ-013 cmd_max_pulses  in  8  inject pulse limit.
REQ-014 settle_cyc, pulse_cyc  in  CNT_BITS each  settle and pulse durations, sampled at accept.
REQ-015 abort  in  1  terminate current operation.
REQ-016 meas_req  out  1  measurement request to external ADC; meas_ack  in  1; meas_val  in  MEAS_BITS.
REQ-017 row_addr  out  ROW_BITS; col_addr  out  COL_BITS  decoder addresses.
REQ-018 prog_mode  out  1  drain-select: 1 = program drains, 0 = run drains.
REQ-019 vinj_pulse, vtun_pulse  out  1 each  injection / tunnelling enables.
REQ-020 busy  out  1; done  out  1 (one-cycle pulse); status  out  2; pulses_used  out  8.

Function
REQ-021 States SHALL be IDLE, SETUP, PULSE, RECOVER, MEASURE, DONE; all outputs registered.
REQ-022 cmd_ready SHALL be 1 only in IDLE; accept on cmd_valid&cmd_ready latches all cmd_* plus settle_cyc/pulse_cyc, clears pulses_used, enters SETUP.
REQ-023 SETUP: row_addr/col_addr = latched values, prog_mode=1, busy=1; duration settle_cyc+1 cycles.
REQ-024 SETUP exit: cmd_tun=1 -> PULSE; cmd_tun=0 -> MEASURE (pre-check before any pulse).
REQ-025 PULSE: vtun_pulse (tunnel) or vinj_pulse (inject) high for exactly max(pulse_cyc,1) cycles; both never high together; neither high outside PULSE.
REQ-026 Tunnel PULSE exit -> DONE, status=10.
REQ-027 Inject PULSE exit: pulses_used+1, -> RECOVER (prog_mode=1, settle_cyc+1 cycles) -> MEASURE.
REQ-028 MEASURE: prog_mode=0, meas_req held high until the cycle meas_ack=1; meas_val sampled that cycle; meas_req low next cycle; meas_ack while meas_req=0 ignored.
REQ-029 Post-measure: meas_val >= target (unsigned) -> DONE status=00; else pulses_used == max_pulses -> DONE status=01; else -> PULSE.
REQ-030 cmd_max_pulses=0: one measurement, no pulse; below target -> status=01, pulses_used=0.
REQ-031 abort high in any state except IDLE/DONE -> DONE next cycle, status=11, pulse enables low that cycle; abort in IDLE ignored, cmd_ready unaffected.
REQ-032 DONE: one cycle, done=1, prog_mode=0, busy=0 next cycle; -> IDLE; status, pulses_used, addresses hold until next accept.
REQ-033 busy SHALL be 1 in SETUP, PULSE, RECOVER, MEASURE, DONE.

Reset
REQ-034 rst_n low SHALL force IDLE asynchronously: cmd_ready=1; all other outputs 0; timers and pulses_used 0.
REQ-035 Reset mid-PULSE SHALL drop vinj_pulse/vtun_pulse immediately, without waiting for clk.

Verification
REQ-036 Tunnel row=3 col=17 settle=4 pulse=10 -> SETUP 5 cycles, vtun_pulse 10 cycles, done, status=10, pulses_used=0.
REQ-037 Inject target=500 max=8, ADC returns 100,300,520 -> 2 pulses, status=00, pulses_used=2, meas_req 3 times.
REQ-038 Inject target=900 max=3, ADC always 200 -> 3 pulses, 4 measurements, status=01.
REQ-039 meas_ack delayed 7 cycles -> meas_req held 7+1 cycles, no state advance; stray meas_ack in PULSE ignored.
REQ-040 abort on 3rd PULSE cycle -> vinj_pulse low next cycle, done with status=11; next cmd accepted 2 cycles later.
REQ-041 rst_n low mid-PULSE (async, between edges) -> pulse enables 0 immediately, cmd_ready=1, pulses_used=0.

Source files
------------

// File: rtl/fg_prog_sequencer.sv
// rtl/fg_prog_sequencer.sv - floating-gate program/erase pulse sequencer
module fg_prog_sequencer #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 6,
  parameter int CNT_BITS  = 12,
  parameter int MEAS_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ROW_BITS-1:0]  cmd_row,
  input  logic [COL_BITS-1:0]  cmd_col,
  input  logic                 cmd_tun,
  input  logic [MEAS_BITS-1:0] cmd_target,
  input  logic [7:0]           cmd_max_pulses,
  input  logic [CNT_BITS-1:0]  settle_cyc,
  input  logic [CNT_BITS-1:0]  pulse_cyc,
  input  logic                 abort,
  output logic                 meas_req,
  input  logic                 meas_ack,
  input  logic [MEAS_BITS-1:0] meas_val,
  output logic [ROW_BITS-1:0]  row_addr,
  output logic [COL_BITS-1:0]  col_addr,
  output logic                 prog_mode,
  output logic                 vinj_pulse,
  output logic                 vtun_pulse,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [7:0]           pulses_used
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_RECOVER, S_MEASURE, S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_BITS-1:0]  r_cnt, w_cnt_nxt;
  logic [7:0]           r_used, w_used_nxt;
  logic [1:0]           r_status, w_status_nxt;
  logic                 w_accept;
  logic [CNT_BITS-1:0]  w_pulse_len;

  logic [ROW_BITS-1:0]  r_row;
  logic [COL_BITS-1:0]  r_col;
  logic                 r_tun;
  logic [MEAS_BITS-1:0] r_target;
  logic [7:0]           r_max;
  logic [CNT_BITS-1:0]  r_settle, r_pulse;

  logic r_cmd_ready, r_busy, r_done, r_prog_mode, r_vinj, r_vtun, r_meas_req;

  // A zero pulse length still yields one pulse cycle; counter counts down to 0.
  assign w_pulse_len = (r_pulse == '0) ? '0 : r_pulse - CNT_BITS'(1);

  // Next-state, timer, pulse counter and status decisions
  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    w_used_nxt   = r_used;
    w_status_nxt = r_status;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept     = 1'b1;
          w_next       = S_SETUP;
          w_cnt_nxt    = settle_cyc;
          w_used_nxt   = '0;
          w_status_nxt = 2'b00;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          if (r_tun) begin
            w_next    = S_PULSE;
            w_cnt_nxt = w_pulse_len;
          end else begin
            w_next = S_MEASURE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_BITS'(1);
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          if (r_tun) begin
            w_next       = S_DONE;
            w_status_nxt = 2'b10;
          end else begin
            w_next     = S_RECOVER;
            w_cnt_nxt  = r_settle;
            w_used_nxt = r_used + 8'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_BITS'(1);
        end
      end
      S_RECOVER: begin
        if (r_cnt == '0) w_next = S_MEASURE;
        else             w_cnt_nxt = r_cnt - CNT_BITS'(1);
      end
      S_MEASURE: begin
        if (meas_ack && r_meas_req) begin
          if (meas_val >= r_target) begin
            w_next       = S_DONE;
            w_status_nxt = 2'b00;
          end else if (r_used == r_max) begin
            w_next       = S_DONE;
            w_status_nxt = 2'b01;
          end else begin
            w_next    = S_PULSE;
            w_cnt_nxt = w_pulse_len;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every decision above while an operation is in flight.
    if (abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
      w_next       = S_DONE;
      w_status_nxt = 2'b11;
      w_cnt_nxt    = r_cnt;
      w_used_nxt   = r_used;
    end
  end

  // State, command latches and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_used      <= '0;
      r_status    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_tun       <= 1'b0;
      r_target    <= '0;
      r_max       <= '0;
      r_settle    <= '0;
      r_pulse     <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_prog_mode <= 1'b0;
      r_vinj      <= 1'b0;
      r_vtun      <= 1'b0;
      r_meas_req  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nxt;
      r_used   <= w_used_nxt;
      r_status <= w_status_nxt;
      if (w_accept) begin
        r_row    <= cmd_row;
        r_col    <= cmd_col;
        r_tun    <= cmd_tun;
        r_target <= cmd_target;
        r_max    <= cmd_max_pulses;
        r_settle <= settle_cyc;
        r_pulse  <= pulse_cyc;
      end
      r_cmd_ready <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      r_prog_mode <= (w_next == S_SETUP) || (w_next == S_PULSE) || (w_next == S_RECOVER);
      r_vinj      <= (w_next == S_PULSE) && !r_tun;
      r_vtun      <= (w_next == S_PULSE) && r_tun;
      r_meas_req  <= (w_next == S_MEASURE);
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign prog_mode   = r_prog_mode;
  assign vinj_pulse  = r_vinj;
  assign vtun_pulse  = r_vtun;
  assign meas_req    = r_meas_req;
  assign row_addr    = r_row;
  assign col_addr    = r_col;
  assign status      = r_status;
  assign pulses_used = r_used;

endmodule
